// File: rtl/view_ray_gen_if.sv
// ============================================================================
//  view_ray_gen_if : ray output handshake plus the pixel tag that rides with it
//  Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface view_ray_gen_if #(
    parameter int NW = 10,
    parameter int ZW = 8,
    parameter int XB = 7,
    parameter int YB = 6
);
    logic               ray_valid;
    logic               ray_ready;
    logic [2*NW+ZW-1:0] ray_out;
    logic [XB-1:0]      pix_x;
    logic [YB-1:0]      pix_y;
    logic               ray_last;

    modport master (output ray_valid, ray_out, pix_x, pix_y, ray_last, input ray_ready);
    modport slave  (input ray_valid, ray_out, pix_x, pix_y, ray_last, output ray_ready);
endinterface

`default_nettype wire

// File: rtl/view_ray_gen.sv
// ============================================================================
//  view_ray_gen : per-pixel view ray generator (sqrt + shared restoring divider)
//  Optional macro VIEW_RAY_SAT_EN saturates rays instead of wrapping.
//  Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module view_ray_gen #(
    parameter int NW = 10,
    parameter int ZW = 8,
    parameter int DW = 10,
    parameter int XB = 7,
    parameter int YB = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2*NW+ZW-1:0] view_normal,
    input  logic [DW-1:0]      view_dist,
    view_ray_gen_if.master     ray,
    output logic               busy,
    output logic               done,
    output logic               err
);
    localparam int RW = NW + 1;
    localparam int QW = NW + DW + 2;
    localparam int SW = QW + 1;
    localparam int CW = $clog2(QW);
    localparam int XC = 2**(XB-1) - 1;
    localparam int YC = 2**(YB-1) - 1;

    typedef enum logic [2:0] {S_IDLE, S_SQRT, S_DIVX, S_DIVY, S_OUT, S_DONE} state_t;
    state_t state, state_nx;

    logic signed [NW-1:0] dx, dy;
    logic [DW-1:0]        d0;
    logic [CW-1:0]        cnt;
    logic [2*RW-1:0]      rad;
    logic [RW:0]          rem;
    logic [RW-1:0]        root;
    logic [QW-1:0]        num;
    logic [RW-1:0]        drem;
    logic                 neg;
    logic signed [NW-1:0] rx, ry;
    logic signed [ZW-1:0] rz;
    logic [XB-1:0]        pix_x;
    logic [YB-1:0]        pix_y;
    logic                 ray_last;
    logic                 load_x, load_y;

    function automatic logic signed [NW-1:0] fit_n(input logic signed [SW-1:0] v);
`ifdef VIEW_RAY_SAT_EN
        if (v > SW'(2**(NW-1) - 1))    return {1'b0, {(NW-1){1'b1}}};
        if (v < SW'(-(2**(NW-1))))     return {1'b1, {(NW-1){1'b0}}};
`endif
        return NW'(v);
    endfunction

    function automatic logic signed [ZW-1:0] fit_z(input logic signed [SW-1:0] v);
`ifdef VIEW_RAY_SAT_EN
        if (v > SW'(2**(ZW-1) - 1))    return {1'b0, {(ZW-1){1'b1}}};
        if (v < SW'(-(2**(ZW-1))))     return {1'b1, {(ZW-1){1'b0}}};
`endif
        return ZW'(v);
    endfunction

    // Sum of squares of the incoming normal, latched as the sqrt radicand on start
    logic signed [2*RW-1:0] nx_in, ny_in, nz_in;
    logic [2*RW-1:0]        sumsq;
    assign nx_in = {{(2*RW-NW){view_normal[2*NW+ZW-1]}}, view_normal[2*NW+ZW-1 -: NW]};
    assign ny_in = {{(2*RW-NW){view_normal[NW+ZW-1]}}, view_normal[NW+ZW-1 -: NW]};
    assign nz_in = {{(2*RW-ZW){view_normal[ZW-1]}}, view_normal[ZW-1:0]};
    assign sumsq = nx_in * nx_in + ny_in * ny_in + nz_in * nz_in;

    logic [RW+2:0] sq_sh, sq_trial;
    logic          sq_ge;
    logic [RW-1:0] root_nx;
    logic [RW:0]   rem_nx;
    assign sq_sh    = {rem, rad[2*RW-1 -: 2]};
    assign sq_trial = {1'b0, root, 2'b01};
    assign sq_ge    = sq_sh >= sq_trial;
    assign rem_nx   = sq_ge ? (RW+1)'(sq_sh - sq_trial) : sq_sh[RW:0];
    assign root_nx  = {root[RW-2:0], sq_ge};

    logic [RW:0]   d_sh;
    logic          d_ge, div_end, sqrt_end;
    logic [RW-1:0] drem_nx;
    logic [QW-1:0] num_nx;
    assign d_sh     = {drem, num[QW-1]};
    assign d_ge     = d_sh >= {1'b0, root};
    assign drem_nx  = d_ge ? RW'(d_sh - {1'b0, root}) : d_sh[RW-1:0];
    assign num_nx   = {num[QW-2:0], d_ge};
    assign div_end  = (cnt == CW'(QW-1));
    assign sqrt_end = (cnt == CW'(RW-1));

    // Reloading from OUT targets the next pixel, so the offset uses pix_x+1
    logic [XB-1:0]        pix_src;
    logic signed [SW-1:0] d0_s, dx_s, dy_s, xo_s, yo_s, numx, numy, num_sel, q_s;
    assign pix_src = (state == S_OUT) ? pix_x + XB'(1) : pix_x;
    assign d0_s    = {{(SW-DW){1'b0}}, d0};
    assign dx_s    = {{(SW-NW){dx[NW-1]}}, dx};
    assign dy_s    = {{(SW-NW){dy[NW-1]}}, dy};
    assign xo_s    = $signed({{(SW-XB){1'b0}}, pix_src}) - SW'(XC);
    assign yo_s    = $signed({{(SW-YB){1'b0}}, pix_y}) - SW'(YC);
    assign numx    = d0_s * dx_s + xo_s * dy_s;
    assign numy    = d0_s * dy_s - xo_s * dx_s;
    assign num_sel = (state == S_DIVX) ? numy : numx;
    assign q_s     = neg ? -$signed({1'b0, num_nx}) : $signed({1'b0, num_nx});

    assign ray_last      = (&pix_x) & (&pix_y);
    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);
    assign ray.ray_valid = (state == S_OUT);
    assign ray.ray_out   = {rx, ry, rz};
    assign ray.pix_x     = pix_x;
    assign ray.pix_y     = pix_y;
    assign ray.ray_last  = ray_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        load_x   = 1'b0;
        load_y   = 1'b0;
        case (state)
            S_IDLE: if (start) state_nx = S_SQRT;
            S_SQRT: if (sqrt_end) begin
                if (root_nx == '0) state_nx = S_DONE;
                else begin state_nx = S_DIVX; load_x = 1'b1; end
            end
            S_DIVX: if (div_end) begin state_nx = S_DIVY; load_y = 1'b1; end
            S_DIVY: if (div_end) state_nx = S_OUT;
            S_OUT:  if (ray.ray_ready) begin
                if (ray_last) state_nx = S_DONE;
                else begin state_nx = S_DIVX; load_x = 1'b1; end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dx <= '0; dy <= '0; d0 <= '0; cnt <= '0; rad <= '0; rem <= '0;
            root <= '0; num <= '0; drem <= '0; neg <= 1'b0;
            rx <= '0; ry <= '0; rz <= '0; pix_x <= '0; pix_y <= '0; err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    dx    <= view_normal[2*NW+ZW-1 -: NW];
                    dy    <= view_normal[NW+ZW-1 -: NW];
                    d0    <= view_dist;
                    rad   <= sumsq;
                    rem   <= '0;
                    root  <= '0;
                    cnt   <= '0;
                    pix_x <= '0;
                    pix_y <= '0;
                    err   <= 1'b0;
                end
                S_SQRT: begin
                    rem  <= rem_nx;
                    root <= root_nx;
                    rad  <= {rad[2*RW-3:0], 2'b00};
                    cnt  <= cnt + CW'(1);
                    if (sqrt_end && root_nx == '0) err <= 1'b1;
                end
                S_DIVX, S_DIVY: begin
                    drem <= drem_nx;
                    num  <= num_nx;
                    cnt  <= cnt + CW'(1);
                    if (div_end) begin
                        if (state == S_DIVX) rx <= fit_n(q_s);
                        else begin
                            ry <= fit_n(q_s);
                            rz <= fit_z(yo_s);
                        end
                    end
                end
                S_OUT: if (ray.ray_ready) begin
                    pix_x <= pix_x + XB'(1);
                    if (&pix_x) pix_y <= pix_y + YB'(1);
                end
                default: ;
            endcase
            if (load_x || load_y) begin
                num  <= QW'(num_sel[SW-1] ? -num_sel : num_sel);
                neg  <= num_sel[SW-1];
                drem <= '0;
                cnt  <= '0;
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_view_ray_gen.sv
// ============================================================================
//  tb_view_ray_gen : scoreboard bench for view_ray_gen with hand-computed rays
//  Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_view_ray_gen;
    localparam int NW = 10, ZW = 8, DW = 10, XB = 7, YB = 6;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [2*NW+ZW-1:0] view_normal = '0;
    logic [DW-1:0]      view_dist = '0;
    logic               busy, done, err;

    view_ray_gen_if #(.NW(NW), .ZW(ZW), .XB(XB), .YB(YB)) rif ();

    view_ray_gen #(.NW(NW), .ZW(ZW), .DW(DW), .XB(XB), .YB(YB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .view_normal (view_normal),
        .view_dist   (view_dist),
        .ray         (rif.master),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct {int px; int py; int rx; int ry; int rz;} exp_t;
    exp_t sb[$];

    int n_cmp = 0, n_bad = 0;
    int exp_px = 0, exp_py = 0, hs_cnt = 0, last_cnt = 0, done_cnt = 0, valid_cnt = 0;
    int fr_done0 = 0, fr_valid0 = 0;
    logic signed [9:0] m_rx, m_ry;
    logic signed [7:0] m_rz;
    exp_t e;

`ifdef VIEW_RAY_SAT_EN
    localparam int RX_BIG = 511;
`else
    localparam int RX_BIG = -1;
`endif

    task automatic check(input string nm, input longint act, input longint expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    function automatic logic [27:0] pk(input int rx, input int ry, input int rz);
        logic [9:0] a;
        logic [9:0] b;
        logic [7:0] c;
        a = rx[9:0];
        b = ry[9:0];
        c = rz[7:0];
        return {a, b, c};
    endfunction

    function automatic exp_t mk(input int px, input int py, input int rx, input int ry, input int rz);
        exp_t t;
        t.px = px; t.py = py; t.rx = rx; t.ry = ry; t.rz = rz;
        return t;
    endfunction

    // Monitor: every accepted ray is checked against the expected scan order;
    // rays with a scoreboard entry are also checked for their value.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (rif.ray_valid) valid_cnt++;
        if (rif.ray_valid && rif.ray_ready) begin
            check("pix_tag", {rif.ray_last, rif.pix_y, rif.pix_x},
                  {(exp_px == 127 && exp_py == 63), 6'(exp_py), 7'(exp_px)});
            if (rif.ray_last) last_cnt++;
            if (sb.size() > 0 && sb[0].px == int'(rif.pix_x) && sb[0].py == int'(rif.pix_y)) begin
                e    = sb.pop_front();
                m_rx = rif.ray_out[27:18];
                m_ry = rif.ray_out[17:8];
                m_rz = rif.ray_out[7:0];
                check($sformatf("rx(%0d,%0d)", e.px, e.py), m_rx, e.rx);
                check($sformatf("ry(%0d,%0d)", e.px, e.py), m_ry, e.ry);
                check($sformatf("rz(%0d,%0d)", e.px, e.py), m_rz, e.rz);
            end
            hs_cnt++;
            exp_px++;
            if (exp_px == 128) begin
                exp_px = 0;
                exp_py++;
            end
        end
    end

    task automatic start_frame(input int dx, input int dy, input int dz, input int d0);
        logic [9:0] a;
        logic [9:0] b;
        logic [7:0] c;
        a = dx[9:0]; b = dy[9:0]; c = dz[7:0];
        @(posedge clk); #1;
        view_normal = {a, b, c};
        view_dist   = d0[9:0];
        exp_px = 0; exp_py = 0; hs_cnt = 0; last_cnt = 0;
        fr_done0 = done_cnt; fr_valid0 = valid_cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_cnt == fr_done0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check("done_pulses", done_cnt - fr_done0, 1);
    endtask

    function automatic int outs_word();
        return {rif.ray_valid, rif.ray_last, busy, done, err,
                |rif.ray_out, |rif.pix_x, |rif.pix_y};
    endfunction

    initial begin
        rif.ray_ready = 1'b1;
        #12;
        check("reset_outputs", outs_word(), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Zero normal: error, one done pulse, no rays
        start_frame(0, 0, 0, 5);
        wait_done(100);
        check("err_set", err, 1);
        check("err_frame_valids", valid_cnt - fr_valid0, 0);
        check("idle_busy", busy, 0);
        repeat (10) @(posedge clk);
        #1;
        check("err_hold", err, 1);

        // Full frame d=(3,4,0), d0=10 with a 5-cycle stall on the first ray
        sb.push_back(mk(0, 0, -44, 45, -31));
        sb.push_back(mk(0, 31, -44, 45, 0));
        sb.push_back(mk(63, 31, 6, 8, 0));
        sb.push_back(mk(127, 63, 57, -30, 32));
        rif.ray_ready = 1'b0;
        start_frame(3, 4, 0, 10);
        check("err_clear", err, 0);
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (rif.ray_valid) break;
        end
        check("first_valid", rif.ray_valid, 1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall_hold%0d", i),
                  {rif.ray_out, rif.pix_y, rif.pix_x, rif.ray_valid},
                  {pk(-44, 45, -31), 6'd0, 7'd0, 1'b1});
            @(posedge clk); #1;
        end
        check("stall_no_hs", hs_cnt, 0);
        rif.ray_ready = 1'b1;
        wait_done(400000);
        check("frame_handshakes", hs_cnt, 8192);
        check("frame_last_count", last_cnt, 1);
        check("frame_sb_empty", sb.size(), 0);
        check("frame_err", err, 0);

        // d=(1,0,0), d0=1023; reset pulse mid-DIVX after pixel (63,0)
        sb.push_back(mk(0, 0, RX_BIG, 63, -31));
        sb.push_back(mk(63, 0, RX_BIG, 0, -31));
        start_frame(1, 0, 0, 1023);
        for (int i = 0; i < 5000 && hs_cnt < 64; i++) @(posedge clk);
        check("f2_reach_px63", hs_cnt, 64);
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midframe_reset_outputs", outs_word(), 0);
        check("f2_sb_empty", sb.size(), 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        fr_valid0 = valid_cnt;
        repeat (200) @(posedge clk);
        #1;
        check("post_reset_valids", valid_cnt - fr_valid0, 0);
        check("post_reset_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/view_ray_gen.md
VIEW_RAY_GEN -- requirements
Module: view_ray_gen

Interface
REQ-001 The block SHALL have parameter NW, default 10: signed width of view-normal x/y components and of ray x/y outputs.
REQ-002 The block SHALL have parameter ZW, default 8: signed width of view-normal z component and of ray z output.
REQ-003 The block SHALL have parameter DW, default 10: unsigned width of view distance.
REQ-004 The block SHALL have parameters XB, default 7, and YB, default 6: screen column and row counter widths.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port start, input, 1 bit: frame request, sampled only in IDLE.
REQ-008 The block SHALL have port view_normal, input, 2*NW+ZW bits: packed {dx,dy,dz}, all signed.
REQ-009 The block SHALL have port view_dist, input, DW bits: unsigned d0.
REQ-010 The block SHALL have ports ray_valid (output, 1 bit) and ray_ready (input, 1 bit): output handshake.
REQ-011 The block SHALL have port ray_out, output, 2*NW+ZW bits: packed {rx,ry,rz}, all signed.
REQ-012 The block SHALL have ports pix_x (output, XB bits), pix_y (output, YB bits) and ray_last (output, 1 bit): the pixel tag travelling with ray_out.
REQ-013 The block SHALL have ports busy, done and err, outputs, 1 bit each.

Function
REQ-014 FSM states SHALL be IDLE, SQRT, DIVX, DIVY, OUT, DONE; busy SHALL be 1 in every state except IDLE.
REQ-015 In IDLE, start=1 SHALL latch view_normal and view_dist, clear pix_x/pix_y to 0, clear err, and enter SQRT; start outside IDLE SHALL be ignored.
REQ-016 SQRT SHALL compute L = floor(sqrt(dx^2+dy^2+dz^2)) with a one-result-bit-per-cycle restoring algorithm, taking exactly NW+1 cycles.
REQ-017 If L=0, the block SHALL set err=1 and enter DONE without emitting any ray; otherwise it SHALL enter DIVX.
REQ-018 Offsets SHALL be xo = pix_x - (2^(XB-1)-1) and yo = pix_y - (2^(YB-1)-1), both signed.
REQ-019 DIVX SHALL compute rx = (d0*dx + xo*dy)/L; DIVY SHALL compute ry = (d0*dy - xo*dx)/L; rz SHALL be yo sign-extended or truncated to ZW bits.
REQ-020 Each division SHALL use one shared restoring divider on magnitudes, take exactly NW+DW+2 cycles, and truncate toward zero, with the sign reapplied afterwards.
REQ-021 In OUT, ray_valid SHALL be 1, and ray_out, pix_x, pix_y and ray_last SHALL stay stable until a cycle in which ray_valid and ray_ready are both 1.
REQ-022 ray_last SHALL be 1 only for pix_x = 2^XB-1 and pix_y = 2^YB-1.
REQ-023 On handshake, pix_x SHALL increment; pix_x wrap from 2^XB-1 to 0 SHALL increment pix_y; after the last pixel the FSM SHALL enter DONE, otherwise DIVX.
REQ-024 DONE SHALL last one cycle with done=1, then return to IDLE; err SHALL hold until the next accepted start.

Reset
REQ-025 While rst_n=0, regardless of clk, the block SHALL force state IDLE, ray_valid=0, ray_out=0, pix_x=0, pix_y=0, ray_last=0, busy=0, done=0 and err=0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame; no ray SHALL be emitted after reset release until a new start.

Configuration
REQ-027 With macro VIEW_RAY_SAT_EN defined, rx and ry SHALL saturate to [-2^(NW-1), 2^(NW-1)-1] and rz to the ZW range.
REQ-028 Without VIEW_RAY_SAT_EN, rx, ry and rz SHALL be the low bits of the full-precision result (two's-complement wrap).

Verification (NW=10, ZW=8, DW=10, XB=7, YB=6)
REQ-029 The bench SHALL cover: d=(3,4,0), d0=10, pixel (63,31) -> ray_out rx=6, ry=8, rz=0.
REQ-030 The bench SHALL cover: same frame, pixel (0,31) -> rx=-44, ry=45, rz=0.
REQ-031 The bench SHALL cover: d=(1,0,0), d0=1023, pixel (63,0) -> rx=511 with VIEW_RAY_SAT_EN, rx=-1 without; rz=-31 in both.
REQ-032 The bench SHALL cover: d=(0,0,0), start -> err=1, a single done pulse, and ray_valid never asserted.
REQ-033 The bench SHALL cover: ray_ready held 0 for 5 cycles during OUT -> ray_out and pix_x/pix_y unchanged, exactly one ray accepted, and a full frame of exactly 8192 handshakes with ray_last on the last one only.
REQ-034 The bench SHALL cover: rst_n pulsed low mid-DIVX -> all outputs immediately 0 and no valid until the next start.
